// File: rtl/if_fetch_queue.sv
// ============================================================================
// if_fetch_queue
// Instruction-fetch stage: generates sequential PCs, issues requests to
// instruction memory (valid/ready, variable latency, in-order responses) and
// buffers returned instructions in a QDEPTH-entry in-order queue that feeds
// decode over a valid/ready handshake. A redirect flushes the queue and
// discards the responses of requests still in flight.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   redirect_valid, redirect_pc     flush and restart fetch at redirect_pc
//   imem_req_valid/ready/addr       fetch request channel
//   imem_rsp_valid/data             fetch response channel (always accepted)
//   id_valid/ready, id_pc/instr     instruction channel to decode
//   rsp_err                         sticky: response with nothing outstanding
// ============================================================================
module if_fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     QDEPTH   = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [31:0]     id_instr,
    output logic            rsp_err
);

    localparam int unsigned PTRW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CNTW = $clog2(QDEPTH) + 1;
    localparam int unsigned SUMW = CNTW + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic [PTRW-1:0] head;
    logic [PTRW-1:0] fill;
    logic [PTRW-1:0] tail;
    logic [CNTW-1:0] count;     // allocated entries
    logic [CNTW-1:0] pend;      // allocated entries still waiting for data
    logic [CNTW-1:0] drop_cnt;  // in-flight responses belonging to flushed entries

    logic credit_ok;
    logic head_filled;
    logic req_fire;
    logic id_fire;
    logic rsp_drop;
    logic rsp_fill;
    logic rsp_orphan;
    logic unused_ok;

    assign unused_ok = &{1'b0, redirect_pc[1:0]};

    // Outstanding requests (pending + to-be-dropped) are capped at QDEPTH.
    assign credit_ok = (SUMW'(count) + SUMW'(drop_cnt)) < SUMW'(QDEPTH);

    // Entries fill in order, so the head is filled whenever any entry is.
    assign head_filled = count > pend;

    assign imem_req_valid = rst_n & ~redirect_valid & credit_ok;
    assign imem_req_addr  = pc;

    assign id_valid = rst_n & ~redirect_valid & head_filled;
    assign id_pc    = id_valid ? q_pc[head]    : '0;
    assign id_instr = id_valid ? q_instr[head] : '0;

    assign req_fire = imem_req_valid & imem_req_ready;
    assign id_fire  = id_valid & id_ready;

    // Response classification: flushed first, then pending, otherwise orphan.
    assign rsp_drop   = imem_rsp_valid & (drop_cnt != '0);
    assign rsp_fill   = imem_rsp_valid & (drop_cnt == '0) & (pend != '0);
    assign rsp_orphan = imem_rsp_valid & (drop_cnt == '0) & (pend == '0);

    // Queue storage (no reset needed; validity is tracked by the counters).
    always_ff @(posedge clk) begin
        if (req_fire) begin
            q_pc[tail] <= pc;
        end
        if (rsp_fill && rst_n && !redirect_valid) begin
            q_instr[fill] <= imem_rsp_data;
        end
    end

    // Control state: pointers, counters, PC and sticky error.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc       <= RESET_PC;
            head     <= '0;
            fill     <= '0;
            tail     <= '0;
            count    <= '0;
            pend     <= '0;
            drop_cnt <= '0;
            rsp_err  <= 1'b0;
        end else if (redirect_valid) begin
            pc    <= {redirect_pc[XLEN-1:2], 2'b00};
            head  <= '0;
            fill  <= '0;
            tail  <= '0;
            count <= '0;
            pend  <= '0;
            // Every pending request becomes a response to throw away.
            if (imem_rsp_valid && drop_cnt == '0 && pend == '0) begin
                rsp_err  <= 1'b1;
                drop_cnt <= '0;
            end else begin
                drop_cnt <= drop_cnt + pend - CNTW'(imem_rsp_valid);
            end
        end else begin
            if (req_fire) begin
                tail <= tail + PTRW'(1);
                pc   <= pc + XLEN'(4);
            end
            if (rsp_fill) begin
                fill <= fill + PTRW'(1);
            end
            if (id_fire) begin
                head <= head + PTRW'(1);
            end
            count <= count + CNTW'(req_fire) - CNTW'(id_fire);
            pend  <= pend + CNTW'(req_fire) - CNTW'(rsp_fill);
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - CNTW'(1);
            end
            if (rsp_orphan) begin
                rsp_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// ============================================================================
// tb_if_fetch_queue
// Randomized bench for if_fetch_queue: a memory model with variable in-order
// latency, random decode stalls, redirects, resets and unsolicited responses.
// Expected outputs come from a queue-based reference model of the fetch rules.
// ============================================================================
module tb_if_fetch_queue;

    localparam int QD = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic        rsp_err;

    always #5 clk = ~clk;

    if_fetch_queue #(.XLEN(32), .RESET_PC(RST_PC), .QDEPTH(QD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .rsp_err        (rsp_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    // Memory model: in-flight requests in issue order.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mem_t;
    mem_t mq[$];

    // Reference model of the fetch stage.
    logic [31:0] m_pc;
    logic [31:0] m_pcs[$];   // allocated entries, oldest first
    logic [31:0] m_ins[$];   // data of filled entries, oldest first
    int          m_drop;
    bit          m_err;
    bit          known = 0;

    initial begin
        int cyc = 0;
        int lat, p_rdy, p_idr, p_redir, p_stall, p_rst;
        bit spur;
        bit e_req, e_idv, req_f, id_f;
        int unf;
        logic [31:0] pc_old;

        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        id_ready = 1'b0;
        m_pc = RST_PC; m_drop = 0; m_err = 0;

        for (int ph = 0; ph < 8; ph++) begin
            case (ph)
                0: begin lat = 1; p_rdy = 100; p_idr = 100; p_redir = 0; p_stall = 0;  p_rst = 0; spur = 0; end
                1: begin lat = 1; p_rdy = 100; p_idr = 10;  p_redir = 0; p_stall = 0;  p_rst = 0; spur = 0; end
                2: begin lat = 3; p_rdy = 100; p_idr = 80;  p_redir = 5; p_stall = 0;  p_rst = 0; spur = 0; end
                3: begin lat = 2; p_rdy = 60;  p_idr = 60;  p_redir = 8; p_stall = 30; p_rst = 0; spur = 0; end
                4: begin lat = 1; p_rdy = 80;  p_idr = 50;  p_redir = 10; p_stall = 20; p_rst = 1; spur = 0; end
                5: begin lat = 4; p_rdy = 90;  p_idr = 90;  p_redir = 6; p_stall = 10; p_rst = 1; spur = 0; end
                6: begin lat = 2; p_rdy = 70;  p_idr = 40;  p_redir = 4; p_stall = 20; p_rst = 0; spur = 1; end
                default: begin lat = 3; p_rdy = 50; p_idr = 70; p_redir = 6; p_stall = 40; p_rst = 1; spur = 1; end
            endcase

            for (int n = 0; n < 400; n++) begin
                @(negedge clk);
                // Drive inputs for this cycle.
                if (ph == 0 && n < 2) rst_n = 1'b0;
                else rst_n = ($urandom_range(199) < p_rst) ? 1'b0 : 1'b1;
                redirect_valid = rst_n && ($urandom_range(99) < p_redir);
                redirect_pc    = $urandom;
                if ($urandom_range(1) == 0) redirect_pc[31:12] = '0;
                imem_req_ready = $urandom_range(99) < p_rdy;
                id_ready       = $urandom_range(99) < p_idr;
                imem_rsp_valid = 1'b0;
                imem_rsp_data  = $urandom;
                if (rst_n) begin
                    if (mq.size() > 0) begin
                        if (mq[0].due <= cyc && $urandom_range(99) >= p_stall) begin
                            imem_rsp_valid = 1'b1;
                            imem_rsp_data  = mem_word(mq[0].addr);
                        end
                    end else if (spur && $urandom_range(39) == 0) begin
                        imem_rsp_valid = 1'b1;
                    end
                end
                #1;
                // Expected outputs from the model.
                unf   = m_pcs.size() - m_ins.size();
                e_req = rst_n && !redirect_valid && (m_pcs.size() + m_drop < QD);
                e_idv = rst_n && !redirect_valid && (m_ins.size() > 0);
                check("req_valid", 32'(imem_req_valid), 32'(e_req));
                if (known && rst_n) check("req_addr", imem_req_addr, m_pc);
                check("id_valid", 32'(id_valid), 32'(e_idv));
                check("id_pc", id_pc, e_idv ? m_pcs[0] : 32'h0);
                check("id_instr", id_instr, e_idv ? m_ins[0] : 32'h0);
                if (known) check("rsp_err", 32'(rsp_err), 32'(m_err));
                req_f = e_req && imem_req_ready;
                id_f  = e_idv && id_ready;

                @(posedge clk);
                // Advance the model and the memory.
                if (!rst_n) begin
                    m_pc = RST_PC; m_pcs.delete(); m_ins.delete();
                    m_drop = 0; m_err = 0; mq.delete(); known = 1;
                end else begin
                    pc_old = m_pc;
                    if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
                    if (redirect_valid) begin
                        if (imem_rsp_valid && m_drop + unf == 0) m_err = 1;
                        else m_drop = m_drop + unf - (imem_rsp_valid ? 1 : 0);
                        m_pcs.delete(); m_ins.delete();
                        m_pc = {redirect_pc[31:2], 2'b00};
                    end else begin
                        if (id_f) begin
                            void'(m_pcs.pop_front());
                            void'(m_ins.pop_front());
                        end
                        if (imem_rsp_valid) begin
                            if (m_drop > 0) m_drop--;
                            else if (unf > 0) m_ins.push_back(imem_rsp_data);
                            else m_err = 1;
                        end
                        if (req_f) begin
                            m_pcs.push_back(pc_old);
                            m_pc = pc_old + 32'd4;
                            mq.push_back('{addr: pc_old, due: cyc + lat});
                        end
                    end
                end
                cyc++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
